data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 94 +++++++++
 tb/tb_data_memory.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with combinational loads,
// clocked stores, size/alignment checking and a synchronous full clear.
module data_memory #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  output logic [31:0] dout,
  output logic        exception
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic                  access;
  logic                  unused_addr_hi;

  // Upper address bits are deliberately not decoded, so accesses wrap.
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH];

  assign a0 = addr[ADDR_WIDTH-1:0];
  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  assign access = memRead | memWrite;

  // Flag illegal sizes and misaligned halfword/word accesses; independent of rst.
  always_comb begin
    exception = 1'b0;
    if (access) begin
      case (memSize)
        2'b01:   exception = addr[0];
        2'b10:   exception = (addr[1:0] != 2'b00);
        2'b11:   exception = 1'b1;
        default: exception = 1'b0;
      endcase
    end
  end

  // Clear the whole array on reset, otherwise commit legal stores byte by byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (memWrite && !exception) begin
      case (memSize)
        2'b00: begin
          mem[a0] <= din[7:0];
        end
        2'b01: begin
          mem[a0] <= din[7:0];
          mem[a1] <= din[15:8];
        end
        2'b10: begin
          mem[a0] <= din[7:0];
          mem[a1] <= din[15:8];
          mem[a2] <= din[23:16];
          mem[a3] <= din[31:24];
        end
        default: ;
      endcase
    end
  end

  // Combinational load path with optional sign extension; zero when idle or faulting.
  always_comb begin
    dout = 32'h0000_0000;
    if (memRead && !exception) begin
      case (memSize)
        2'b00:   dout = {{24{memSign & b0[7]}}, b0};
        2'b01:   dout = {{16{memSign & b1[7]}}, b1, b0};
        2'b10:   dout = {b3, b2, b1, b0};
        default: dout = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory using an expected-result queue.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  memSize;
  logic        memSign;
  logic [31:0] dout;
  logic        exception;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic [31:0] dout;
    logic        exc;
  } exp_t;

  exp_t sb[$];

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  data_memory #(.ADDR_WIDTH(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .din       (din),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .memSize   (memSize),
    .memSign   (memSign),
    .dout      (dout),
    .exception (exception)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic check_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: got 0 entries, required >= 1");
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (dout === e.dout) else begin
      miscompares++;
      $error("FAIL %s dout: got %h, required %h", e.tag, dout, e.dout);
    end
    vectors++;
    assert (exception === e.exc) else begin
      miscompares++;
      $error("FAIL %s exception: got %b, required %b", e.tag, exception, e.exc);
    end
  endtask

  // Drive one access after a falling edge, check outputs, optionally clock it in.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] exp_d, input logic exp_e,
                      input string tag, input bit clock_it);
    exp_t e;
    @(negedge clk);
    memRead  = rd;
    memWrite = wr;
    addr     = a;
    din      = d;
    memSize  = sz;
    memSign  = sgn;
    e.tag  = tag;
    e.dout = exp_d;
    e.exc  = exp_e;
    sb.push_back(e);
    #1;
    check_outputs();
    if (clock_it) begin
      @(posedge clk);
      #1;
    end
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    addr     = '0;
    din      = '0;
    memWrite = 1'b0;
    memRead  = 1'b0;
    memSize  = SZ_W;
    memSign  = 1'b0;

    repeat (4) @(posedge clk);
    step(1'b1, 1'b0, 32'd3, 32'd0, SZ_W, 1'b0, 32'h0, 1'b1, "exc_during_rst", 1'b1);
    rst = 1'b0;

    step(1'b1, 1'b0, 32'd0,     32'd0, SZ_W, 1'b0, 32'h0, 1'b0, "rst_lw0",   1'b0);
    step(1'b1, 1'b0, 32'h100,   32'd0, SZ_W, 1'b0, 32'h0, 1'b0, "rst_lw100", 1'b0);
    step(1'b1, 1'b0, 32'hFFC,   32'd0, SZ_W, 1'b0, 32'h0, 1'b0, "rst_lwffc", 1'b0);

    step(1'b0, 1'b1, 32'd0, 32'h12345678, SZ_W, 1'b0, 32'h0, 1'b0, "sw0", 1'b1);
    step(1'b0, 1'b1, 32'd4, 32'h12345678, SZ_H, 1'b0, 32'h0, 1'b0, "sh4", 1'b1);
    step(1'b1, 1'b0, 32'd4, 32'd0, SZ_W, 1'b0, 32'h00005678, 1'b0, "lw4_after_sh", 1'b0);
    step(1'b0, 1'b1, 32'd6, 32'hFFFFFFFF, SZ_B, 1'b0, 32'h0, 1'b0, "sb6", 1'b1);
    step(1'b0, 1'b1, 32'd7, 32'hEEEEEEEE, SZ_B, 1'b0, 32'h0, 1'b0, "sb7", 1'b1);

    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0, 32'h12345678, 1'b0, "lw0", 1'b0);
    step(1'b1, 1'b0, 32'd4, 32'd0, SZ_W, 1'b0, 32'hEEFF5678, 1'b0, "lw4", 1'b0);
    step(1'b1, 1'b0, 32'd6, 32'd0, SZ_H, 1'b1, 32'hFFFFEEFF, 1'b0, "lh6",  1'b0);
    step(1'b1, 1'b0, 32'd6, 32'd0, SZ_H, 1'b0, 32'h0000EEFF, 1'b0, "lhu6", 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_B, 1'b1, 32'h00000078, 1'b0, "lb0",  1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_B, 1'b0, 32'h00000078, 1'b0, "lbu0", 1'b0);
    step(1'b1, 1'b0, 32'd6, 32'd0, SZ_B, 1'b1, 32'hFFFFFFFF, 1'b0, "lb6",  1'b0);
    step(1'b1, 1'b0, 32'd6, 32'd0, SZ_B, 1'b0, 32'h000000FF, 1'b0, "lbu6", 1'b0);
    step(1'b1, 1'b0, 32'd2, 32'd0, SZ_H, 1'b0, 32'h00001234, 1'b0, "lhu2", 1'b0);
    step(1'b1, 1'b0, 32'd3, 32'd0, SZ_B, 1'b1, 32'h00000012, 1'b0, "lb3",  1'b0);

    step(1'b1, 1'b0, 32'd3, 32'd0, SZ_W, 1'b0, 32'h0, 1'b1, "lw3_misal", 1'b0);
    step(1'b1, 1'b0, 32'd5, 32'd0, SZ_H, 1'b0, 32'h0, 1'b1, "lh5_misal", 1'b0);
    step(1'b0, 1'b1, 32'd2, 32'hDEADBEEF, SZ_W, 1'b0, 32'h0, 1'b1, "sw2_misal", 1'b1);
    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0, 32'h12345678, 1'b0, "lw0_after_misal", 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_X, 1'b0, 32'h0, 1'b1, "size11_read", 1'b0);
    step(1'b0, 1'b1, 32'd0, 32'hBAADF00D, SZ_X, 1'b0, 32'h0, 1'b1, "size11_write", 1'b1);
    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0, 32'h12345678, 1'b0, "lw0_after_size11", 1'b0);
    step(1'b0, 1'b0, 32'd3, 32'd0, SZ_W, 1'b0, 32'h0, 1'b0, "idle", 1'b0);

    step(1'b1, 1'b1, 32'd4, 32'hCAFEBABE, SZ_W, 1'b0, 32'hEEFF5678, 1'b0, "rw_pre_edge", 1'b1);
    step(1'b1, 1'b0, 32'd4, 32'd0, SZ_W, 1'b0, 32'hCAFEBABE, 1'b0, "lw4_after_rw", 1'b0);

    step(1'b0, 1'b1, 32'h00001000, 32'hA5A5A5A5, SZ_W, 1'b0, 32'h0, 1'b0, "sw_wrap", 1'b1);
    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0, 32'hA5A5A5A5, 1'b0, "lw0_wrap", 1'b0);

    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 32'd0, 32'h11111111, SZ_W, 1'b0, 32'h0, 1'b0, "sw_during_rst", 1'b1);
    rst = 1'b0;
    step(1'b1, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0, 32'h0, 1'b0, "lw0_after_rst", 1'b0);
    step(1'b1, 1'b0, 32'd4, 32'd0, SZ_W, 1'b0, 32'h0, 1'b0, "lw4_after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
